// File: rtl/bkram_pkg.sv
// Shared types and geometry helpers for the backup-RAM transfer sequencer.
package bkram_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    XFER,
    DONE
  } state_e;

  typedef enum logic {
    DIR_LOAD,
    DIR_SAVE
  } dir_e;

  function automatic int calcSw(input int ramAw, input int sectAw);
    return ramAw - sectAw;
  endfunction

  function automatic int slotWidth(input int slots);
    return (slots > 1) ? $clog2(slots) : 1;
  endfunction

endpackage

// File: rtl/bkram_xfer_ctrl.sv
// Multi-slot BSRAM <-> SD-image sector sequencer with ack timeout and status pulses.
// Optional dirty tracking (save skipped when BSRAM unmodified): define BKRAM_DIRTY_EN.
module bkram_xfer_ctrl
  import bkram_pkg::*;
#(
  parameter int RAM_AW  = 17,
  parameter int SECT_AW = 9,
  parameter int SLOTS   = 4,
  parameter int LBA_W   = 32,
  parameter int ACK_TO  = 2**24,
  localparam int SLW    = slotWidth(SLOTS)
) (
  input  logic             clk_sys_i,
  input  logic             RESET_N_i,
  input  logic [23:0]      ram_mask_i,
  input  logic             bk_ena_i,
  input  logic             load_req_i,
  input  logic             save_req_i,
  input  logic             dl_end_i,
  input  logic [SLW-1:0]   slot_i,
  input  logic             bsram_we_i,
  input  logic             sd_ack_i,
  output logic [LBA_W-1:0] sd_lba_o,
  output logic             sd_rd_o,
  output logic             sd_wr_o,
  output logic             loading_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             error_o,
  output logic             dirty_o
);

  localparam int SW = calcSw(RAM_AW, SECT_AW);
  localparam int CW = $clog2(ACK_TO + 1);

  state_e         state_q, state_d;
  dir_e           dir_q, dir_d;
  logic [SLW-1:0] slot_q, slot_d;
  logic [SW-1:0]  idx_q, idx_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           sdRd_q, sdRd_d;
  logic           sdWr_q, sdWr_d;
  logic           busy_q, busy_d;
  logic           loading_q, loading_d;
  logic           done_q, done_d;
  logic           error_q, error_d;
  logic           dirty_q, dirty_d;
  logic           loadReq_q, saveReq_q, sdAck_q;

  logic           loadRise, saveRise, ackRise, startOk, startLoad;
  logic [SW-1:0]  lastIdx;
  logic [SLW-1:0] slotSel;
  logic [LBA_W-1:0] slotExt;

  assign loadRise  = load_req_i & ~loadReq_q;
  assign saveRise  = save_req_i & ~saveReq_q;
  assign ackRise   = sd_ack_i & ~sdAck_q;
  assign startOk   = bk_ena_i && (ram_mask_i != 24'd0);
  assign startLoad = dl_end_i | loadRise;
  assign lastIdx   = ram_mask_i[RAM_AW-1:SECT_AW];
  assign slotSel   = (SLOTS > 1) ? slot_i : '0;

  // Edge registers track every cycle so a level held through a transfer never retriggers.
  always_ff @(posedge clk_sys_i or negedge RESET_N_i) begin
    if (!RESET_N_i) begin
      loadReq_q <= 1'b0;
      saveReq_q <= 1'b0;
      sdAck_q   <= 1'b0;
    end else begin
      loadReq_q <= load_req_i;
      saveReq_q <= save_req_i;
      sdAck_q   <= sd_ack_i;
    end
  end

  always_ff @(posedge clk_sys_i or negedge RESET_N_i) begin
    if (!RESET_N_i) begin
      state_q   <= IDLE;
      dir_q     <= DIR_LOAD;
      slot_q    <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      sdRd_q    <= 1'b0;
      sdWr_q    <= 1'b0;
      busy_q    <= 1'b0;
      loading_q <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      dirty_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      slot_q    <= slot_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      sdRd_q    <= sdRd_d;
      sdWr_q    <= sdWr_d;
      busy_q    <= busy_d;
      loading_q <= loading_d;
      done_q    <= done_d;
      error_q   <= error_d;
      dirty_q   <= dirty_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    slot_d    = slot_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    sdRd_d    = sdRd_q;
    sdWr_d    = sdWr_q;
    busy_d    = busy_q;
    loading_d = loading_q;
    done_d    = 1'b0;
    error_d   = 1'b0;
`ifdef BKRAM_DIRTY_EN
    dirty_d   = dirty_q | bsram_we_i;
`else
    dirty_d   = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (startOk && (startLoad || saveRise)) begin
          idx_d  = '0;
          cnt_d  = '0;
          busy_d = 1'b1;
          if (startLoad) begin
            dir_d     = DIR_LOAD;
            slot_d    = dl_end_i ? '0 : slotSel;
            loading_d = 1'b1;
            sdRd_d    = 1'b1;
            state_d   = REQ;
          end else begin
            dir_d  = DIR_SAVE;
            slot_d = slotSel;
`ifdef BKRAM_DIRTY_EN
            if (!dirty_q) begin
              state_d = DONE;
            end else begin
              sdWr_d  = 1'b1;
              state_d = REQ;
            end
`else
            sdWr_d  = 1'b1;
            state_d = REQ;
`endif
          end
        end
      end

      REQ: begin
        if (ackRise) begin
          sdRd_d  = 1'b0;
          sdWr_d  = 1'b0;
          state_d = XFER;
        end else if (cnt_q == CW'(ACK_TO - 1)) begin
          sdRd_d    = 1'b0;
          sdWr_d    = 1'b0;
          error_d   = 1'b1;
          busy_d    = 1'b0;
          loading_d = 1'b0;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      XFER: begin
        if (!sd_ack_i) begin
          if (idx_q == lastIdx) begin
            state_d = DONE;
          end else begin
            idx_d = idx_q + SW'(1);
            cnt_d = '0;
            if (dir_q == DIR_LOAD) sdRd_d = 1'b1;
            else                   sdWr_d = 1'b1;
            state_d = REQ;
          end
        end
      end

      DONE: begin
        done_d    = 1'b1;
        busy_d    = 1'b0;
        loading_d = 1'b0;
`ifdef BKRAM_DIRTY_EN
        dirty_d   = bsram_we_i;
`else
        dirty_d   = 1'b0;
`endif
        state_d   = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

`ifndef BKRAM_DIRTY_EN
  logic unusedWe;
  assign unusedWe = bsram_we_i;
`endif

  assign slotExt   = LBA_W'(slot_q);
  assign sd_lba_o  = (slotExt << SW) + LBA_W'(idx_q);
  assign sd_rd_o   = sdRd_q;
  assign sd_wr_o   = sdWr_q;
  assign loading_o = loading_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign error_o   = error_q;
  assign dirty_o   = dirty_q;

endmodule

// File: tb/tb_bkram_xfer_ctrl.sv
// Self-checking bench for bkram_xfer_ctrl: acts as the HPS sector responder and
// compares every request against sector addresses computed from mask and slot.
module tb_bkram_xfer_ctrl;

  localparam int TO = 40;

  logic        clk = 1'b0;
  logic        rstN;
  logic [23:0] ramMask;
  logic        bkEna, loadReq, saveReq, dlEnd, bsramWe, sdAck;
  logic [1:0]  slot;
  logic [31:0] sdLba;
  logic        sdRd, sdWr, loading, busy, done, error, dirty;

  int compared = 0;
  int mismatched = 0;
  int doneCnt = 0;
  int errCnt = 0;
  int reqRises = 0;
  logic reqPrev = 1'b0;

  bkram_xfer_ctrl #(
    .RAM_AW(17), .SECT_AW(9), .SLOTS(4), .LBA_W(32), .ACK_TO(TO)
  ) dut (
    .clk_sys_i(clk), .RESET_N_i(rstN), .ram_mask_i(ramMask), .bk_ena_i(bkEna),
    .load_req_i(loadReq), .save_req_i(saveReq), .dl_end_i(dlEnd), .slot_i(slot),
    .bsram_we_i(bsramWe), .sd_ack_i(sdAck), .sd_lba_o(sdLba), .sd_rd_o(sdRd),
    .sd_wr_o(sdWr), .loading_o(loading), .busy_o(busy), .done_o(done),
    .error_o(error), .dirty_o(dirty)
  );

  always #5 clk = ~clk;

  // Event counters sampled on the falling edge, ahead of the main sequence.
  always @(negedge clk) begin
    if (done) doneCnt++;
    if (error) errCnt++;
    if ((sdRd | sdWr) && !reqPrev) reqRises++;
    reqPrev = sdRd | sdWr;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // kind: 0 = load edge, 1 = save edge, 2 = dl_end pulse
  task automatic applyStimulus(input int kind, input int slotv, input logic [23:0] maskv);
    ramMask = maskv;
    slot = 2'(slotv);
    case (kind)
      0: loadReq = 1'b1;
      1: saveReq = 1'b1;
      default: dlEnd = 1'b1;
    endcase
    tick();
    loadReq = 1'b0;
    saveReq = 1'b0;
    dlEnd = 1'b0;
  endtask

  task automatic markDirty();
    bsramWe = 1'b1;
    tick();
    bsramWe = 1'b0;
  endtask

  task automatic waitReq(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (sdRd | sdWr) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Serve nSect sectors (or all when negative); expected LBA = slot * 256 + sector.
  task automatic serviceXfer(input bit isLoad, input int slotv, input logic [23:0] maskv,
                             input int nSect);
    int last, total;
    bit ok;
    last  = int'((maskv >> 9) & 24'hFF);
    total = (nSect < 0) ? last + 1 : nSect;
    for (int i = 0; i < total; i++) begin
      waitReq(ok);
      checkOutput("reqSeen", 32'(ok), 32'd1);
      checkOutput("lba", sdLba, 32'(slotv * 256 + i));
      checkOutput("rdDir", 32'(sdRd), 32'(isLoad));
      checkOutput("wrDir", 32'(sdWr), 32'(!isLoad));
      checkOutput("loading", 32'(loading), 32'(isLoad));
      checkOutput("busyXfer", 32'(busy), 32'd1);
      tick($urandom_range(0, 3));
      sdAck = 1'b1;
      tick();
      checkOutput("reqDrop", 32'(sdRd | sdWr), 32'd0);
      tick($urandom_range(0, 2));
      sdAck = 1'b0;
    end
  endtask

  task automatic waitDone();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("doneSeen", 32'(seen), 32'd1);
    checkOutput("busyAfter", 32'(busy), 32'd0);
    checkOutput("loadingAfter", 32'(loading), 32'd0);
    tick();
    checkOutput("donePulse", 32'(done), 32'd0);
  endtask

  initial begin
    int d0, e0, r0, n;
    bit ok;
    logic [23:0] maskv;
    int slotv;
    bit isLoad;

    rstN = 1'b0; ramMask = 24'd0; bkEna = 1'b1; loadReq = 1'b0; saveReq = 1'b0;
    dlEnd = 1'b0; bsramWe = 1'b0; sdAck = 1'b0; slot = 2'd0;
    tick(3);
    checkOutput("rstRd", 32'(sdRd), 32'd0);
    checkOutput("rstWr", 32'(sdWr), 32'd0);
    checkOutput("rstBusy", 32'(busy), 32'd0);
    checkOutput("rstLoading", 32'(loading), 32'd0);
    checkOutput("rstDone", 32'(done | error), 32'd0);
    checkOutput("rstDirty", 32'(dirty), 32'd0);
    rstN = 1'b1;
    tick(2);

    $display("[TB] 16-sector load, slot 0");
    d0 = doneCnt;
    applyStimulus(0, 0, 24'h1FFF);
    serviceXfer(1'b1, 0, 24'h1FFF, -1);
    waitDone();
    checkOutput("loadDoneCnt", 32'(doneCnt - d0), 32'd1);

    $display("[TB] 4-sector save, slot 2");
    markDirty();
    d0 = doneCnt;
    applyStimulus(1, 2, 24'h7FF);
    serviceXfer(1'b0, 2, 24'h7FF, -1);
    waitDone();
    checkOutput("saveDoneCnt", 32'(doneCnt - d0), 32'd1);

    $display("[TB] dl_end and save edge together");
    markDirty();
    r0 = reqRises; d0 = doneCnt;
    ramMask = 24'h7FF; slot = 2'd3;
    dlEnd = 1'b1; saveReq = 1'b1;
    tick();
    dlEnd = 1'b0;
    serviceXfer(1'b1, 0, 24'h7FF, -1);
    waitDone();
    tick(10);
    checkOutput("dlEndReqCnt", 32'(reqRises - r0), 32'd4);
    checkOutput("dlEndDoneCnt", 32'(doneCnt - d0), 32'd1);
    saveReq = 1'b0;
    tick();

    $display("[TB] ack timeout");
    e0 = errCnt; d0 = doneCnt;
    applyStimulus(0, 0, 24'h1FFF);
    checkOutput("toReqUp", 32'(sdRd), 32'd1);
    n = 0;
    for (int i = 0; i < TO + 10; i++) begin
      tick();
      n++;
      if (error) break;
    end
    checkOutput("toLatency", 32'(n), 32'(TO));
    checkOutput("toRdDrop", 32'(sdRd), 32'd0);
    checkOutput("toBusy", 32'(busy | loading), 32'd0);
    tick(3);
    checkOutput("toErrCnt", 32'(errCnt - e0), 32'd1);
    checkOutput("toNoDone", 32'(doneCnt - d0), 32'd0);

    $display("[TB] reset during sector 3");
    d0 = doneCnt;
    applyStimulus(0, 0, 24'h1FFF);
    serviceXfer(1'b1, 0, 24'h1FFF, 3);
    waitReq(ok);
    checkOutput("rstMidLba", sdLba, 32'd3);
    #2 rstN = 1'b0;
    #1;
    checkOutput("rstMidRd", 32'(sdRd), 32'd0);
    checkOutput("rstMidBusy", 32'(busy | loading), 32'd0);
    checkOutput("rstMidLbaZero", sdLba, 32'd0);
    tick(2);
    rstN = 1'b1;
    tick();
    checkOutput("rstMidNoDone", 32'(doneCnt - d0), 32'd0);
    applyStimulus(0, 0, 24'h1FFF);
    serviceXfer(1'b1, 0, 24'h1FFF, -1);
    waitDone();

    $display("[TB] ignored starts");
    r0 = reqRises; d0 = doneCnt; e0 = errCnt;
    bkEna = 1'b0;
    applyStimulus(0, 1, 24'h1FFF);
    tick(8);
    bkEna = 1'b1;
    applyStimulus(1, 1, 24'h0);
    tick(8);
    checkOutput("ignReq", 32'(reqRises - r0), 32'd0);
    checkOutput("ignPulses", 32'((doneCnt - d0) + (errCnt - e0)), 32'd0);

    $display("[TB] single sector with ack high at entry");
    r0 = reqRises;
    sdAck = 1'b1;
    applyStimulus(0, 1, 24'h1FF);
    tick(3);
    checkOutput("ackHighHold", 32'(sdRd), 32'd1);
    checkOutput("ackHighLba", sdLba, 32'd256);
    sdAck = 1'b0;
    tick();
    checkOutput("ackLowHold", 32'(sdRd), 32'd1);
    sdAck = 1'b1;
    tick();
    checkOutput("ackRiseDrop", 32'(sdRd), 32'd0);
    sdAck = 1'b0;
    waitDone();
    checkOutput("singleReqCnt", 32'(reqRises - r0), 32'd1);

    $display("[TB] randomized transfers");
    for (int it = 0; it < 6; it++) begin
      maskv  = 24'($urandom_range(1, 16'h3FFF));
      slotv  = int'($urandom_range(0, 3));
      isLoad = 1'($urandom_range(0, 1));
      markDirty();
      d0 = doneCnt; r0 = reqRises;
      applyStimulus(isLoad ? 0 : 1, slotv, maskv);
      serviceXfer(isLoad, slotv, maskv, -1);
      waitDone();
      checkOutput("rndDoneCnt", 32'(doneCnt - d0), 32'd1);
      checkOutput("rndReqCnt", 32'(reqRises - r0), 32'(((maskv >> 9) & 24'hFF) + 24'd1));
    end

`ifdef BKRAM_DIRTY_EN
    $display("[TB] dirty tracking enabled");
    applyStimulus(0, 0, 24'h7FF);
    serviceXfer(1'b1, 0, 24'h7FF, -1);
    waitDone();
    checkOutput("dirtyAfterLoad", 32'(dirty), 32'd0);
    r0 = reqRises;
    applyStimulus(1, 1, 24'h7FF);
    checkOutput("cleanSaveBusy", 32'(busy), 32'd1);
    tick();
    checkOutput("cleanSaveDone", 32'(done), 32'd1);
    checkOutput("cleanSaveBusyOff", 32'(busy), 32'd0);
    applyStimulus(1, 1, 24'h7FF);
    bsramWe = 1'b1;
    tick();
    bsramWe = 1'b0;
    checkOutput("weWithDone", 32'(done), 32'd1);
    checkOutput("weWithDoneDirty", 32'(dirty), 32'd1);
    tick(4);
    checkOutput("cleanSaveNoWr", 32'(reqRises - r0), 32'd0);
    applyStimulus(1, 1, 24'h7FF);
    serviceXfer(1'b0, 1, 24'h7FF, -1);
    waitDone();
    checkOutput("dirtySaveClears", 32'(dirty), 32'd0);
`else
    $display("[TB] dirty tracking disabled");
    markDirty();
    checkOutput("dirtyTied", 32'(dirty), 32'd0);
    r0 = reqRises;
    applyStimulus(1, 1, 24'h7FF);
    serviceXfer(1'b0, 1, 24'h7FF, -1);
    waitDone();
    checkOutput("fullSaveReqCnt", 32'(reqRises - r0), 32'd4);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/bkram_xfer_ctrl.md
Name: bkram_xfer_ctrl

Overview:
Multi-slot backup-RAM transfer sequencer between the cartridge BSRAM and the HPS SD-image sector interface. Steps sector-by-sector through the active RAM size for load or save, selecting one of several save slots on the image. Successor to the single-slot save/load logic in the emu top level; adds slots, parametrised sector/RAM geometry, ack timeout and status reporting. Drives `hps_io` sd_lba/sd_rd/sd_wr and the core reset-hold (`loading`).

Parameters:
RAM_AW, 17, max BSRAM byte-address bits (1 Mbit)
SECT_AW, 9, log2 sector size in bytes
SLOTS, 4, number of save slots on the image (power of 2, >=1)
LBA_W, 32, sd_lba width
ACK_TO, 2**24, cycles to wait for sd_ack rise before error

Ports:
clk_sys  in  1  system clock
RESET_N  in  1  reset, asynchronous, active-low
ram_mask  in  24  active BSRAM mask (0 = no BSRAM)
bk_ena  in  1  backup file mounted and writable
load_req  in  1  level; rising edge starts load
save_req  in  1  level; rising edge starts save
dl_end  in  1  1-cycle pulse at ROM download end; starts auto-load of slot 0
slot  in  $clog2(SLOTS) (min 1)  slot index, sampled at start
bsram_we  in  1  BSRAM write strobe from core (dirty tracking)
sd_ack  in  1  HPS sector ack
sd_lba  out  LBA_W  sector address
sd_rd  out  1  read request
sd_wr  out  1  write request
loading  out  1  high during any load; ORed into core reset
busy  out  1  transfer in progress
done  out  1  1-cycle pulse on normal completion
error  out  1  1-cycle pulse on timeout abort
dirty  out  1  BSRAM modified since last load/save

Behaviour:
- All outputs reset to 0; state IDLE; edge registers cleared.
- Sector index width SW = RAM_AW-SECT_AW. last = ram_mask[RAM_AW-1:SECT_AW]. Slot base = slot_latched << SW. sd_lba = base + idx, zero-extended to LBA_W.
- Starts accepted only in IDLE with bk_ena=1 and ram_mask!=0; otherwise ignored (no done/error).
- Priority for simultaneous starts: dl_end > load edge > save edge. Edges arriving while busy are dropped; edge registers still track, so a held level does not retrigger.
- States:
  - IDLE: on start, latch dir and slot, idx=0, busy=1, loading=dir_load; assert sd_rd (load) or sd_wr (save); go REQ.
  - REQ: timeout counter runs. On sd_ack rise, drop sd_rd/sd_wr on the same edge; go XFER. If the counter reaches ACK_TO, drop requests, pulse error, clear busy/loading, go IDLE.
  - XFER: wait for sd_ack fall. If idx==last, go DONE. Else idx+1, re-assert request, clear counter, go REQ.
  - DONE: pulse done, clear busy/loading and dirty, go IDLE.
- Single-sector RAM (last=0): exactly one request, then done.
- sd_ack already high at entry to REQ: wait for low, then rise (edge-detected).
- RESET_N low mid-transfer: immediate abort to reset values. No done or error pulse.

Optional Feature:
BKRAM_DIRTY_EN
- Defined: dirty set by bsram_we (cleared on done). A save start with dirty=0 completes with no SD traffic: done pulses 1 cycle after the start edge, busy high for that one cycle. bsram_we and done in the same cycle: dirty ends at 1.
- Undefined: dirty tied 0; every save executes in full.

Decomposition:
- Package bkram_pkg: state enum (IDLE, REQ, XFER, DONE); dir enum (DIR_LOAD, DIR_SAVE); SW derivation function.
- No sub-module. The timeout counter is inline.

Test Plan:
- ram_mask=0x1FFF, slot=0, load edge, bench acks each request: 16 reads, sd_lba 0..15, loading high throughout, one done pulse, busy low after.
- ram_mask=0x7FF, slot=2, save edge: 4 writes at sd_lba 512..515, loading stays 0.
- dl_end and save edge in the same cycle: load of slot 0 runs, save dropped, no second transfer.
- No ack after the first request: error pulses at ACK_TO cycles, sd_rd drops, busy/loading clear.
- RESET_N low during sector 3 of a load: all outputs 0 asynchronously, no done; a new load after reset restarts at sd_lba 0.
- BKRAM_DIRTY_EN defined, no bsram_we since last load, save edge: done with zero sd_wr. After one bsram_we, a save runs in full and dirty clears.
